rom_rd_arbiter: RTL

Two-requester read arbiter sharing one combinational-read ROM port between an instruction-fetch master (m0) and a data-load master (m1). Each master issues word-address read requests over a valid/ready handshake. The block grants the ROM port round-robin, registers the ROM output into a per-master response buffer, and returns it over a second valid/ready handshake. It sits between the core front-end/LSU and the ROM instance.

---
 rtl/rom_pkg.sv | 12 +
 rtl/rr_arb2.sv | 18 +
 rtl/rom_rd_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/rom_pkg.sv
// Shared ROM/RAM client definitions: default geometry and the grant-index encoding.
package rom_pkg;

  localparam int ROM_AW = 10;
  localparam int ROM_DW = 32;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } gnt_idx_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker, purely combinational; a lone requester always wins,
// and on a tie the requester that was not granted last wins.
module rr_arb2
  import rom_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_idx_e   last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_grant == GNT_M0) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/rom_rd_arbiter.sv
// Round-robin share of one combinational ROM port between fetch (m0) and load (m1); 1-cycle read latency.
// A master whose response buffer is full and not being drained is never granted, which stalls only that master.
module rom_rd_arbiter
  import rom_pkg::*;
#(
  parameter int AW = ROM_AW,
  parameter int DW = ROM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req_valid,
  output logic          m0_req_ready,
  input  logic [AW-1:0] m0_req_addr,
  output logic          m0_rsp_valid,
  input  logic          m0_rsp_ready,
  output logic [DW-1:0] m0_rsp_data,
  input  logic          m1_req_valid,
  output logic          m1_req_ready,
  input  logic [AW-1:0] m1_req_addr,
  output logic          m1_rsp_valid,
  input  logic          m1_rsp_ready,
  output logic [DW-1:0] m1_rsp_data,
  output logic [AW-1:0] rom_raddr,
  input  logic [DW-1:0] rom_rdata
);

  logic       m0_elig;
  logic       m1_elig;
  logic [1:0] req;
  logic [1:0] gnt;
  gnt_idx_e   last_grant;

  // A full buffer may still accept when it is being drained in the same cycle.
  assign m0_elig = !m0_rsp_valid || m0_rsp_ready;
  assign m1_elig = !m1_rsp_valid || m1_rsp_ready;
  assign req     = {m1_req_valid && m1_elig, m0_req_valid && m0_elig};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign m0_req_ready = gnt[0];
  assign m1_req_ready = gnt[1];
  assign rom_raddr    = gnt[1] ? m1_req_addr : m0_req_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rsp_valid <= 1'b0;
      m0_rsp_data  <= '0;
      m1_rsp_valid <= 1'b0;
      m1_rsp_data  <= '0;
      last_grant   <= GNT_M1;
    end else begin
      if (gnt[0]) begin
        m0_rsp_valid <= 1'b1;
        m0_rsp_data  <= rom_rdata;
      end else if (m0_rsp_ready) begin
        m0_rsp_valid <= 1'b0;
      end

      if (gnt[1]) begin
        m1_rsp_valid <= 1'b1;
        m1_rsp_data  <= rom_rdata;
      end else if (m1_rsp_ready) begin
        m1_rsp_valid <= 1'b0;
      end

      if (gnt[0]) begin
        last_grant <= GNT_M0;
      end else if (gnt[1]) begin
        last_grant <= GNT_M1;
      end
    end
  end

endmodule
